// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard detection and stall sequencing for the five-stage pipeline.
// Drives PC/IF-ID write enables, ID/EX bubbles and IF/ID flush, with saturating debug counters.
module hazard_stall_controller #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        idRs,
  input  logic [4:0]        idRt,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  input  logic              idIsBranch,
  input  logic              idFlushRequest,
  input  logic              exRegWrite,
  input  logic              exMemRead,
  input  logic [4:0]        exWriteRegister,
  input  logic              memRegWrite,
  input  logic              memMemRead,
  input  logic [4:0]        memWriteRegister,
  input  logic              freeze,
  output logic              pcWrite,
  output logic              ifIdWrite,
  output logic              idExBubble,
  output logic              ifIdFlush,
  output logic              stallActive,
  output logic [STAT_W-1:0] stallCycles,
  output logic [STAT_W-1:0] flushCount
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  state_t      r_state;
  state_t      w_next_state;
  logic        r_rem;
  logic        w_next_rem;
  logic [1:0]  w_need;
  logic        w_ex_hit;
  logic        w_mem_hit;
  logic [STAT_W-1:0] r_stall_cycles;
  logic [STAT_W-1:0] r_flush_count;
  logic        w_unused;

  // Register $0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] d);
    return (a == d) && (d != 5'd0);
  endfunction

  function automatic logic id_reads(input logic [4:0] d);
    return (idUsesRs && reg_match(idRs, d)) || (idUsesRt && reg_match(idRt, d));
  endfunction

  // A MEM-stage ALU result is always forwardable, so memRegWrite alone never stalls.
  assign w_unused  = memRegWrite;
  assign w_ex_hit  = id_reads(exWriteRegister);
  assign w_mem_hit = id_reads(memWriteRegister);

  always_comb begin
    w_need = 2'd0;
    if (exMemRead && w_ex_hit) begin
      w_need = idIsBranch ? 2'd2 : 2'd1;
    end else if (idIsBranch && exRegWrite && w_ex_hit) begin
      w_need = 2'd1;
    end else if (idIsBranch && memMemRead && w_mem_hit) begin
      w_need = 2'd1;
    end else begin
      w_need = 2'd0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_rem   = r_rem;
    pcWrite      = 1'b1;
    ifIdWrite    = 1'b1;
    idExBubble   = 1'b0;
    stallActive  = 1'b0;
    if (reset) begin
      pcWrite      = 1'b0;
      ifIdWrite    = 1'b0;
      idExBubble   = 1'b1;
      w_next_state = ST_RUN;
      w_next_rem   = 1'b0;
    end else if (freeze) begin
      // Front end holds completely; state and rem are preserved.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_need != 2'd0) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExBubble  = 1'b1;
            stallActive = 1'b1;
            if (w_need == 2'd2) begin
              w_next_state = ST_STALL;
              w_next_rem   = 1'b1;
            end else begin
              w_next_state = ST_RUN;
            end
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_STALL: begin
          pcWrite     = 1'b0;
          ifIdWrite   = 1'b0;
          idExBubble  = 1'b1;
          stallActive = 1'b1;
          if (r_rem) begin
            w_next_state = ST_RUN;
            w_next_rem   = 1'b0;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state = ST_RUN;
          w_next_rem   = 1'b0;
        end
      endcase
    end
  end

  // Branch decisions taken with stale operands are dropped while stalling.
  assign ifIdFlush = idFlushRequest && !stallActive && !freeze && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_rem   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stallActive && !freeze && (r_stall_cycles != STAT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + STAT_ONE;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (ifIdFlush && (r_flush_count != STAT_MAX)) begin
        r_flush_count <= r_flush_count + STAT_ONE;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign stallCycles = r_stall_cycles;
  assign flushCount  = r_flush_count;

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequencing controller for the five-stage pipeline's decode stage: detects data hazards between the instruction in ID and older instructions in EX/MEM, and drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush. Branch comparison is resolved in ID, so branch operands must stall until they can be forwarded from EX/MEM outputs. A small FSM holds multi-cycle stalls. Saturating counters record stall and flush activity for debug.

## Interface
- STAT_W, default 16, width of each statistics counter
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- idRs / idRt  in  5 each  source register addresses of the instruction in ID
- idUsesRs / idUsesRt  in  1 each  ID instruction actually reads rs / rt
- idIsBranch  in  1  ID instruction is a conditional branch (compares in ID)
- idFlushRequest  in  1  taken branch or jump decided in ID (decode's ifFlush)
- exRegWrite, exMemRead  in  1 each  control bits of instruction in EX
- exWriteRegister  in  5  destination register of instruction in EX
- memRegWrite, memMemRead  in  1 each  control bits of instruction in MEM
- memWriteRegister  in  5  destination register of instruction in MEM
- freeze  in  1  data memory busy; the whole front end holds
- pcWrite  out  1  PC register write enable
- ifIdWrite  out  1  IF/ID register write enable
- idExBubble  out  1  zero all ID/EX control bits (insert NOP)
- ifIdFlush  out  1  clear IF/ID (squash fetched instruction)
- stallActive  out  1  a hazard stall is in effect this cycle
- stallCycles  out  STAT_W  saturating count of stalled cycles
- flushCount  out  STAT_W  saturating count of flushes issued

## Operation
- match(a, d) = a == d and d != 0; register $0 never creates a hazard.
- Need N (stall cycles), computed combinationally in RUN; maximum of the applicable cases, 0 if none:
  - exMemRead and ID reads a matching EX dest: N=2 if idIsBranch, else N=1.
  - idIsBranch, exRegWrite, !exMemRead, ID reads a matching EX dest: N=1.
  - idIsBranch, memMemRead, ID reads a matching MEM dest: N=1.
  - "ID reads" means (idUsesRs and match(idRs,…)) or (idUsesRt and match(idRt,…)).
- FSM states RUN, STALL; 1-bit remaining counter rem.
  - RUN, N=0: pcWrite=1, ifIdWrite=1, idExBubble=0, stallActive=0.
  - RUN, N>=1: stallActive=1, pcWrite=0, ifIdWrite=0, idExBubble=1. N=2 -> STALL, rem<=1; N=1 -> stay RUN (re-evaluated next cycle).
  - STALL: stall outputs asserted regardless of inputs; rem==1 -> RUN next cycle. N is not evaluated in STALL.
- ifIdFlush = idFlushRequest and !stallActive and !freeze; a branch decision made with stale operands is ignored.
- freeze has top priority: pcWrite=0, ifIdWrite=0, idExBubble=0, ifIdFlush=0, stallActive=0; FSM state, rem and counters hold.
- stallCycles increments on each non-frozen cycle with stallActive=1; flushCount increments on each cycle with ifIdFlush=1. Both saturate at 2^STAT_W-1 and never wrap.

## Timing
- Control outputs are combinational from state and current inputs, valid in the same cycle as the hazard (zero latency). State, rem and counters update on the rising edge of clk.
- Load-use into a non-branch: 1 bubble. Load into a branch: 2 bubbles. ALU result into a branch: 1 bubble.
- While reset is high: state=RUN, rem=0, stallCycles=0, flushCount=0, pcWrite=0, ifIdWrite=0, idExBubble=1, ifIdFlush=0, stallActive=0.
- Reset mid-STALL aborts the stall immediately. First cycle after release is RUN.
- Simultaneous stall and flush request: stall wins and no flush is issued. Decode re-requests after the stall.
- freeze during STALL: rem does not decrement, and the remaining stall cycle completes after freeze drops.

## Test plan
- Reset: assert reset mid-operation -> all outputs and counters at reset values within the same cycle; state RUN after release.
- Load-use: exMemRead=1, exWriteRegister=5, idRs=5, idUsesRs=1, non-branch -> exactly 1 cycle of pcWrite=0 and idExBubble=1; stallCycles=1.
- Load-to-branch: same as above with idIsBranch=1 -> 2 consecutive stall cycles, then RUN; stallCycles=2. Repeat with freeze=1 in the second cycle -> 3 cycles total, counters unchanged while frozen.
- $0 and unused operands: exWriteRegister=0, idRs=0 -> no stall. Matching idRt with idUsesRt=0 -> no stall.
- Flush arbitration: idFlushRequest=1 with no hazard -> ifIdFlush=1 and flushCount+1. With a simultaneous ALU-to-branch hazard -> ifIdFlush=0 and a 1-cycle stall.
- Saturation: STAT_W=2, 5 stall cycles -> stallCycles sticks at 3.
